// File: rtl/eq_i2s_output.sv
// eq_i2s_output
// Output stage of the ten-band equalizer. The summed band result arrives one
// channel at a time. Each sample is scaled and saturated to 16 bits. A left
// sample and the following right sample form one stereo frame. Frames are
// queued in a small FIFO and sent to the DAC as an I2S stream.
//
// Ports
//   Clk, Reset      system clock; synchronous active-high reset
//   Enable          runs the serializer; when low the serializer is held idle
//                   (pairing and FIFO writes keep working)
//   SumValid        one-cycle strobe qualifying SumData / SumRight
//   SumData         signed summed sample, SUM_W bits
//   SumRight        channel of SumData: 0 left, 1 right
//   ClrFlags        clears the sticky flags (a same-cycle set event wins)
//   SumReady        registered FIFO-not-full
//   FifoLevel       registered number of stored frames
//   Bclk, Lrclk     I2S bit clock and word select (0 = left)
//   SData           I2S serial data, MSB first, one Bclk behind Lrclk
//   Overflow        sticky: a frame was dropped because the FIFO was full
//   Underflow       sticky: a frame slot found the FIFO empty after the first push
//   PairErr         sticky: left/right strobes arrived out of sequence
module eq_i2s_output #(
    parameter int SUM_W      = 20,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Enable,
    input  logic                        SumValid,
    input  logic [SUM_W-1:0]            SumData,
    input  logic                        SumRight,
    input  logic                        ClrFlags,
    output logic                        SumReady,
    output logic [$clog2(FIFO_DEPTH):0] FifoLevel,
    output logic                        Bclk,
    output logic                        Lrclk,
    output logic                        SData,
    output logic                        Overflow,
    output logic                        Underflow,
    output logic                        PairErr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(BCLK_DIV);

    localparam logic [PTR_W:0]          FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0]        DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic signed [SUM_W-1:0] SAT_POS    = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] SAT_NEG    = SUM_W'(-32768);

    // ------------------------------------------------------------------
    // Scaling and saturation
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0] scaled;
    logic [15:0]             sat_val;

    always_comb begin
        scaled = $signed(SumData) >>> SHIFT;
        if (scaled > SAT_POS) begin
            sat_val = 16'h7FFF;
        end else if (scaled < SAT_NEG) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = scaled[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Channel pairing
    // ------------------------------------------------------------------
    logic        left_req;
    logic        push_req;
    logic        left_pend_reg;
    logic [15:0] left_hold_reg;
    logic        started_reg;
    logic [31:0] push_frame;

    assign left_req = SumValid & ~SumRight;
    assign push_req = SumValid & SumRight;

    // A right sample with no pending left sample still produces a frame. The
    // left half of that frame is zero.
    assign push_frame = {(left_pend_reg ? left_hold_reg : 16'h0000), sat_val};

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             sum_ready_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop;
    logic [31:0]      head_word;

    // "Full" means full before this cycle's pop. A push that meets a full
    // FIFO is dropped even if a pop happens in the same cycle.
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);
    assign push_ok    = push_req & ~fifo_full;

    // The FIFO is only a few frames deep. The head is read combinationally,
    // so a pop can load the shift register in the same cycle.
    assign head_word = fifo_mem[rd_ptr_reg];

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_frame;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            sum_ready_reg <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg     <= count_next;
            sum_ready_reg <= (count_next != FULL_COUNT);
        end
    end

    // ------------------------------------------------------------------
    // Bit clock generator and serializer
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic             bclk_reg;
    logic             lrclk_reg;
    logic             sdata_reg;
    logic [31:0]      shift_reg;
    logic [4:0]       bit_cnt_reg;
    logic [4:0]       bit_cnt_next;
    logic             div_last;
    logic             bclk_fall;
    logic             frame_load;
    logic [31:0]      load_word;

    assign div_last     = (div_cnt_reg == DIV_LAST);
    // Bclk is high and about to toggle, so this is the falling-edge cycle.
    assign bclk_fall    = Enable & bclk_reg & div_last;
    assign bit_cnt_next = bit_cnt_reg + 5'd1;
    assign frame_load   = bclk_fall & (bit_cnt_next == 5'd0);
    assign pop          = frame_load & ~fifo_empty;
    assign load_word    = fifo_empty ? 32'h0000_0000 : head_word;

    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            lrclk_reg   <= 1'b0;
            sdata_reg   <= 1'b0;
            shift_reg   <= 32'h0000_0000;
            bit_cnt_reg <= 5'd31;
        end else begin
            if (div_last) begin
                div_cnt_reg <= '0;
                bclk_reg    <= ~bclk_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end

            if (bclk_fall) begin
                bit_cnt_reg <= bit_cnt_next;
                if (bit_cnt_next == 5'd0) begin
                    shift_reg <= load_word;
                    sdata_reg <= load_word[31];
                end else begin
                    shift_reg <= {shift_reg[30:0], 1'b0};
                    sdata_reg <= shift_reg[30];
                end
                // Word select changes one bit before each channel's MSB.
                if (bit_cnt_next == 5'd15) begin
                    lrclk_reg <= 1'b1;
                end else if (bit_cnt_next == 5'd31) begin
                    lrclk_reg <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pairing state and sticky flags
    // ------------------------------------------------------------------
    logic ovf_reg, unf_reg, perr_reg;
    logic ovf_next, unf_next, perr_next;

    always_comb begin
        ovf_next  = (ovf_reg  & ~ClrFlags) | (push_req & fifo_full);
        unf_next  = (unf_reg  & ~ClrFlags) | (frame_load & fifo_empty & started_reg);
        perr_next = (perr_reg & ~ClrFlags) | (left_req & left_pend_reg) |
                    (push_req & ~left_pend_reg);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            left_pend_reg <= 1'b0;
            left_hold_reg <= 16'h0000;
            started_reg   <= 1'b0;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
            perr_reg      <= 1'b0;
        end else begin
            if (push_req) begin
                left_pend_reg <= 1'b0;
            end else if (left_req) begin
                left_pend_reg <= 1'b1;
            end
            if (left_req) begin
                left_hold_reg <= sat_val;
            end
            if (push_ok) begin
                started_reg <= 1'b1;
            end
            ovf_reg  <= ovf_next;
            unf_reg  <= unf_next;
            perr_reg <= perr_next;
        end
    end

    assign SumReady  = sum_ready_reg;
    assign FifoLevel = count_reg;
    assign Bclk      = bclk_reg;
    assign Lrclk     = lrclk_reg;
    assign SData     = sdata_reg;
    assign Overflow  = ovf_reg;
    assign Underflow = unf_reg;
    assign PairErr   = perr_reg;

endmodule
